axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arb_pkg.sv | 6 +
 rtl/arb_id_fifo.sv | 37 +++
 rtl/axi_rd_arbiter.sv | 80 ++++++++
 tb/tb_axi_rd_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arb_pkg.sv
// axi_rd_arb_pkg: shared AXI constants and AR state encoding for the read arbiter
package axi_rd_arb_pkg;
  localparam logic [2:0] ARSIZE_64B = 3'b011;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
  typedef enum logic {IDLE, ISSUE} state_t;
endpackage

// File: rtl/arb_id_fifo.sv
// arb_id_fifo: in-flight grant FIFO, 1-bit requester id per entry
module arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: 2:1 AXI read arbiter, round-robin by default, fixed priority with AXI_RD_ARB_FIXED_PRIO_EN
module axi_rd_arbiter #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic [2*C_S_AXI_ADDR_WIDTH-1:0] s_araddr,
  input  logic [15:0] s_arlen,
  input  logic [1:0] s_arvalid,
  output logic [1:0] s_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_rdata,
  output logic s_rlast,
  output logic [1:0] s_rvalid,
  input  logic [1:0] s_rready,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] M_axi_araddr,
  output logic [7:0] M_axi_arlen,
  output logic [2:0] M_axi_arsize,
  output logic [1:0] M_axi_arburst,
  output logic M_axi_arvalid,
  input  logic M_axi_arready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] M_axi_rdata,
  input  logic [1:0] M_axi_rresp,
  input  logic M_axi_rlast,
  input  logic M_axi_rvalid,
  output logic M_axi_rready
);
  import axi_rd_arb_pkg::*;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  state_t state, next;
  logic grant, win, id, push, pop, full, empty, head, route, unused;
  logic [AW-1:0] addr_q;
  logic [7:0] len_q;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  assign win = ~s_arvalid[0];
`else
  logic last;
  assign win = &s_arvalid ? ~last : s_arvalid[1];
  always_ff @(posedge clk)
    if (reset) last <= 1'b1;
    else if (grant) last <= win;
`endif
  always_comb begin
    grant = state == IDLE && |s_arvalid && !full && !reset;
    push = state == ISSUE && M_axi_arready;
    next = grant ? ISSUE : push ? IDLE : state;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      len_q <= '0;
      id <= 1'b0;
    end else if (grant) begin
      addr_q <= win ? s_araddr[AW +: AW] : s_araddr[0 +: AW];
      len_q <= win ? s_arlen[15:8] : s_arlen[7:0];
      id <= win;
    end
  end
  arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .din(id), .pop(pop),
    .head(head), .full(full), .empty(empty)
  );
  assign s_arready = {grant & win, grant & ~win};
  assign M_axi_arvalid = state == ISSUE && !reset;
  assign M_axi_araddr = addr_q;
  assign M_axi_arlen = len_q;
  assign M_axi_arsize = ARSIZE_64B;
  assign M_axi_arburst = ARBURST_INCR;
  // R path is purely combinational off the FIFO head; response code never affects routing
  assign route = !empty && !reset;
  assign s_rvalid = {route & M_axi_rvalid & head, route & M_axi_rvalid & ~head};
  assign M_axi_rready = route & s_rready[head];
  assign s_rdata = M_axi_rdata;
  assign s_rlast = M_axi_rlast;
  assign pop = M_axi_rvalid & M_axi_rready & M_axi_rlast;
  assign unused = ^M_axi_rresp;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: vector table, directed corner sequences and randomized model check for axi_rd_arbiter
module tb_axi_rd_arbiter;
  localparam int MAXO = 4;
  logic clk = 1'b0;
  logic reset;
  logic [63:0] s_araddr;
  logic [15:0] s_arlen;
  logic [1:0] s_arvalid, s_arready, s_rvalid, s_rready;
  logic [63:0] s_rdata;
  logic s_rlast;
  logic [31:0] M_axi_araddr;
  logic [7:0] M_axi_arlen;
  logic [2:0] M_axi_arsize;
  logic [1:0] M_axi_arburst, M_axi_rresp;
  logic M_axi_arvalid, M_axi_arready, M_axi_rlast, M_axi_rvalid, M_axi_rready;
  logic [63:0] M_axi_rdata;
  int checks = 0;
  int failures = 0;

  axi_rd_arbiter #(.C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(64), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .M_axi_araddr(M_axi_araddr), .M_axi_arlen(M_axi_arlen),
    .M_axi_arsize(M_axi_arsize), .M_axi_arburst(M_axi_arburst), .M_axi_arvalid(M_axi_arvalid),
    .M_axi_arready(M_axi_arready), .M_axi_rdata(M_axi_rdata), .M_axi_rresp(M_axi_rresp),
    .M_axi_rlast(M_axi_rlast), .M_axi_rvalid(M_axi_rvalid), .M_axi_rready(M_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] av; logic ar; logic rv; logic rl; logic [1:0] rr;
    logic [1:0] sar; logic mav; logic [1:0] srv; logic mrr;
  } vec_t;
  vec_t tbl[12];

  // reference model: outstanding bursts as queues, one pending address, last winner
  int m_last, bid, beat, w, h, ng;
  bit busy, has, e_grant, e_mrr;
  logic [31:0] baddr;
  logic [7:0] blen;
  logic [1:0] e_sar, e_srv;
  int q_id[$];
  int q_len[$];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic idle_in();
    s_arvalid = 2'b00;
    M_axi_arready = 1'b0;
    M_axi_rvalid = 1'b0;
    M_axi_rlast = 1'b0;
    M_axi_rresp = 2'b00;
    s_rready = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    s_arvalid = 2'b11;
    M_axi_rvalid = 1'b1;
    s_rready = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arvalid", M_axi_arvalid, 0);
    chk("rst_araddr", M_axi_araddr, 0);
    chk("rst_arlen", M_axi_arlen, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rready", M_axi_rready, 0);
    @(negedge clk);
    reset = 1'b0;
    idle_in();
  endtask

  task automatic model_reset();
    m_last = 1;
    busy = 1'b0;
    beat = 0;
    q_id.delete();
    q_len.delete();
  endtask

  initial begin
    s_araddr = '0;
    s_arlen = '0;
    M_axi_rdata = '0;
    do_reset();
    // first transaction: s0, 0x1000, 8 beats
    s_araddr[31:0] = 32'h1000;
    s_arlen[7:0] = 8'd7;
    s_arvalid = 2'b01;
    M_axi_arready = 1'b1;
    #1;
    chk("first_arready", s_arready, 2'b01);
    chk("first_arvalid_c1", M_axi_arvalid, 0);
    @(negedge clk);
    s_arvalid = 2'b00;
    #1;
    chk("first_arvalid", M_axi_arvalid, 1);
    chk("first_araddr", M_axi_araddr, 32'h1000);
    chk("first_arlen", M_axi_arlen, 7);
    chk("arsize", M_axi_arsize, 3'b011);
    chk("arburst", M_axi_arburst, 2'b01);
    chk("first_no_arready", s_arready, 0);
    @(negedge clk);
    M_axi_arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      M_axi_rvalid = 1'b1;
      M_axi_rdata = 64'hA000 + 64'(i);
      M_axi_rlast = (i == 7);
      s_rready = 2'b11;
      #1;
      chk("first_rvalid", s_rvalid, 2'b01);
      chk("first_rdata", s_rdata, 64'hA000 + 64'(i));
      chk("first_rlast", s_rlast, (i == 7));
      chk("first_rready", M_axi_rready, 1);
      @(negedge clk);
    end
    M_axi_rvalid = 1'b0;
    M_axi_rlast = 1'b0;
    #1;
    chk("first_drained", M_axi_rready, 0);
    @(negedge clk);
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
    tbl[0]  = '{2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0};
    tbl[1]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0};
    tbl[2]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 2'b10, 1'b0, 2'b00, 1'b1};
    tbl[3]  = '{2'b11, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1};
    tbl[4]  = '{2'b11, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0};
    tbl[5]  = '{2'b11, 1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1};
    tbl[6]  = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1};
    tbl[7]  = '{2'b10, 1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 1'b0, 2'b10, 1'b1};
    tbl[8]  = '{2'b00, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 1'b1};
    tbl[9]  = '{2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1};
    tbl[10] = '{2'b00, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 2'b10, 1'b1};
    tbl[11] = '{2'b00, 1'b0, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0};
    do_reset();
    s_araddr = {32'h2000, 32'h1000};
    s_arlen = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      s_arvalid = tbl[i].av;
      M_axi_arready = tbl[i].ar;
      M_axi_rvalid = tbl[i].rv;
      M_axi_rlast = tbl[i].rl;
      s_rready = tbl[i].rr;
      #1;
      chk($sformatf("tbl%0d_arready", i), s_arready, tbl[i].sar);
      chk($sformatf("tbl%0d_arvalid", i), M_axi_arvalid, tbl[i].mav);
      chk($sformatf("tbl%0d_rvalid", i), s_rvalid, tbl[i].srv);
      chk($sformatf("tbl%0d_rready", i), M_axi_rready, tbl[i].mrr);
      @(negedge clk);
    end
    // round-robin with both held valid, then in-order non-interleaved R bursts
    do_reset();
    s_araddr = {32'h2000, 32'h1000};
    s_arlen = {8'd7, 8'd7};
    s_arvalid = 2'b11;
    M_axi_arready = 1'b1;
    ng = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (s_arready != 2'b00) begin
        chk("rr_order", s_arready, (ng % 2 == 0) ? 2'b01 : 2'b10);
        ng++;
      end
      @(negedge clk);
    end
    chk("rr_ngrants", ng, 4);
    s_arvalid = 2'b00;
    M_axi_arready = 1'b0;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++) begin
        M_axi_rvalid = 1'b1;
        M_axi_rlast = (i == 7);
        s_rready = 2'b11;
        #1;
        chk("rr_burst_route", s_rvalid, (b % 2 == 0) ? 2'b01 : 2'b10);
        @(negedge clk);
      end
    idle_in();
`else
    do_reset();
    s_araddr = {32'h2000, 32'h1000};
    s_arvalid = 2'b11;
    M_axi_arready = 1'b1;
    ng = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (s_arready != 2'b00) begin
        chk("fp_winner", s_arready, 2'b01);
        ng++;
      end
      @(negedge clk);
    end
    chk("fp_ngrants", ng, 4);
    idle_in();
`endif
    // AR backpressure: latched request held stable, no new grants
    do_reset();
    s_araddr = {32'h2000, 32'h1000};
    s_arlen = {8'd3, 8'd7};
    s_arvalid = 2'b01;
    #1;
    chk("bp_grant", s_arready, 2'b01);
    @(negedge clk);
    s_arvalid = 2'b11;
    repeat (5) begin
      #1;
      chk("bp_arvalid", M_axi_arvalid, 1);
      chk("bp_araddr", M_axi_araddr, 32'h1000);
      chk("bp_arlen", M_axi_arlen, 7);
      chk("bp_no_grant", s_arready, 0);
      @(negedge clk);
    end
    M_axi_arready = 1'b1;
    #1;
    chk("bp_release", M_axi_arvalid, 1);
    @(negedge clk);
    M_axi_arready = 1'b0;
    #1;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    chk("bp_next", s_arready, 2'b01);
`else
    chk("bp_next", s_arready, 2'b10);
`endif
    @(negedge clk);
    // FIFO full, pop reopens, push+pop at MAX-1 keeps count
    do_reset();
    s_arlen = 16'h0000;
    s_arvalid = 2'b11;
    M_axi_arready = 1'b1;
    ng = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (s_arready != 2'b00) ng++;
      @(negedge clk);
    end
    chk("full_grants", ng, MAXO);
    M_axi_rvalid = 1'b1;
    M_axi_rlast = 1'b1;
    s_rready = 2'b11;
    #1;
    chk("full_hold", s_arready, 0);
    chk("full_pop_rready", M_axi_rready, 1);
    @(negedge clk);
    M_axi_rvalid = 1'b0;
    #1;
    chk("full_5th_grant", |s_arready, 1);
    @(negedge clk);
    M_axi_rvalid = 1'b1;
    #1;
    chk("pushpop_arvalid", M_axi_arvalid, 1);
    chk("pushpop_rready", M_axi_rready, 1);
    @(negedge clk);
    M_axi_rvalid = 1'b0;
    #1;
    chk("pushpop_6th_grant", |s_arready, 1);
    @(negedge clk);
    repeat (4) begin
      #1;
      chk("pushpop_full", s_arready, 0);
      @(negedge clk);
    end
    // randomized run against the queue model, with a mid-stream reset
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset();
        model_reset();
      end
      s_arvalid = 2'($urandom_range(0, 3));
      s_araddr = {$urandom, $urandom};
      s_arlen = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
      M_axi_arready = ($urandom_range(0, 2) != 0);
      s_rready = 2'($urandom_range(0, 3));
      has = q_id.size() > 0;
      M_axi_rvalid = has && ($urandom_range(0, 3) != 0);
      M_axi_rlast = M_axi_rvalid && (beat == q_len[0]);
      M_axi_rdata = {$urandom, $urandom};
      M_axi_rresp = 2'($urandom_range(0, 3));
      e_grant = !busy && q_id.size() < MAXO && s_arvalid != 2'b00;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
      w = s_arvalid[0] ? 0 : 1;
`else
      w = (s_arvalid == 2'b11) ? 1 - m_last : (s_arvalid[0] ? 0 : 1);
`endif
      e_sar = e_grant ? (w == 1 ? 2'b10 : 2'b01) : 2'b00;
      h = has ? q_id[0] : 0;
      e_mrr = has && s_rready[h];
      e_srv = (has && M_axi_rvalid) ? (h == 1 ? 2'b10 : 2'b01) : 2'b00;
      #1;
      chk("rnd_arready", s_arready, e_sar);
      chk("rnd_arvalid", M_axi_arvalid, busy);
      if (busy) begin
        chk("rnd_araddr", M_axi_araddr, baddr);
        chk("rnd_arlen", M_axi_arlen, blen);
      end
      chk("rnd_rvalid", s_rvalid, e_srv);
      chk("rnd_rready", M_axi_rready, e_mrr);
      chk("rnd_rdata", s_rdata, M_axi_rdata);
      chk("rnd_rlast", s_rlast, M_axi_rlast);
      if (M_axi_rvalid && e_mrr) begin
        if (M_axi_rlast) begin
          void'(q_id.pop_front());
          void'(q_len.pop_front());
          beat = 0;
        end else beat++;
      end
      if (busy && M_axi_arready) begin
        q_id.push_back(bid);
        q_len.push_back(int'(blen));
        busy = 1'b0;
      end
      if (e_grant) begin
        busy = 1'b1;
        bid = w;
        baddr = s_araddr[w*32 +: 32];
        blen = s_arlen[w*8 +: 8];
        m_last = w;
      end
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
